// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Bridges a CPU load/store request channel to a single-port data memory
//   with a registered (next-cycle) read. Word accesses go straight through.
//   Byte and half stores use read-modify-write: RD -> CAP (merge) -> WR.
//   Misaligned, illegal-size and out-of-range requests are answered with
//   respErr and never strobe the memory.
//
//   Build option: define MEM_ACCESS_SUBWORD_EN to enable byte/half
//   accesses. Without it, sizes 00/01 are rejected and the lane
//   extract/merge logic is not built.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   reqValid/reqReady          request handshake (ready only in IDLE)
//   reqWrite, reqSize,
//   reqSigned, reqAddr,
//   reqWdata                   request fields, latched on accept
//   respValid/respReady        response handshake
//   respRdata, respErr         load data (0 for stores/errors), error flag
//   adr                        word address to memory (0 when not accessing)
//   writeIn, writePin          write data and one-cycle write strobe
//   readPin, readOut           one-cycle read strobe, data valid next cycle
module mem_access_unit #(
  parameter int MEM_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respRdata,
  output logic        respErr,
  output logic [31:0] adr,
  output logic [31:0] writeIn,
  output logic        writePin,
  output logic        readPin,
  input  logic [31:0] readOut
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;

  state_t      state_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;
  logic [31:0] adr_reg;
  logic [31:0] write_in_reg;
  logic        write_pin_reg;
  logic        read_pin_reg;
  logic        req_err;
  logic [31:0] load_data;

`ifdef MEM_ACCESS_SUBWORD_EN
  logic        write_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic [1:0]  lane_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merge_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
`else
  logic        unused_subword;
  assign unused_subword = reqSigned;
`endif

  // Request legality, evaluated on the live request while in IDLE.
  always_comb begin
    req_err = 1'b0;
    case (reqSize)
      2'b11: req_err = 1'b1;
      2'b10: req_err = (reqAddr[1:0] != 2'b00);
`ifdef MEM_ACCESS_SUBWORD_EN
      2'b01: req_err = reqAddr[0];
      default: req_err = 1'b0;
`else
      default: req_err = 1'b1;
`endif
    endcase
    if ({2'b00, reqAddr[31:2]} >= MEM_WORDS_U) req_err = 1'b1;
  end

`ifdef MEM_ACCESS_SUBWORD_EN
  // Little-endian lane extract for loads and lane replace for sub-word stores.
  always_comb begin
    sel_byte   = readOut[{lane_reg, 3'b000} +: 8];
    sel_half   = readOut[{lane_reg[1], 4'b0000} +: 16];
    merge_data = readOut;
    case (size_reg)
      2'b00: begin
        load_data = {{24{signed_reg & sel_byte[7]}}, sel_byte};
        merge_data[{lane_reg, 3'b000} +: 8] = wdata_reg[7:0];
      end
      2'b01: begin
        load_data = {{16{signed_reg & sel_half[15]}}, sel_half};
        merge_data[{lane_reg[1], 4'b0000} +: 16] = wdata_reg[15:0];
      end
      default: load_data = readOut;
    endcase
  end
`else
  assign load_data = readOut;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      adr_reg        <= '0;
      write_in_reg   <= '0;
      write_pin_reg  <= 1'b0;
      read_pin_reg   <= 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
      write_reg      <= 1'b0;
      size_reg       <= 2'b00;
      signed_reg     <= 1'b0;
      lane_reg       <= 2'b00;
      wdata_reg      <= '0;
`endif
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      write_pin_reg <= 1'b0;
      read_pin_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (reqValid) begin
`ifdef MEM_ACCESS_SUBWORD_EN
            write_reg  <= reqWrite;
            size_reg   <= reqSize;
            signed_reg <= reqSigned;
            lane_reg   <= reqAddr[1:0];
            wdata_reg  <= reqWdata;
`endif
            if (req_err) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= '0;
            end else if (!reqWrite || reqSize != 2'b10) begin
              state_reg    <= RD;
              read_pin_reg <= 1'b1;
              adr_reg      <= {2'b00, reqAddr[31:2]};
            end else begin
              state_reg     <= WR;
              write_pin_reg <= 1'b1;
              write_in_reg  <= reqWdata;
              adr_reg       <= {2'b00, reqAddr[31:2]};
            end
          end
        end
        RD: state_reg <= CAP;
        CAP: begin
`ifdef MEM_ACCESS_SUBWORD_EN
          if (write_reg) begin
            state_reg     <= WR;
            write_pin_reg <= 1'b1;
            write_in_reg  <= merge_data;
          end else
`endif
          begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= load_data;
            adr_reg        <= '0;
          end
        end
        WR: begin
          state_reg      <= RESP;
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= '0;
          adr_reg        <= '0;
          write_in_reg   <= '0;
        end
        RESP: begin
          if (respReady) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign reqReady  = (state_reg == IDLE);
  assign respValid = resp_valid_reg;
  assign respErr   = resp_err_reg;
  assign respRdata = resp_rdata_reg;
  assign adr       = adr_reg;
  assign writeIn   = write_in_reg;
  // Reset kills a strobe in the very cycle it is raised, even mid-WR.
  assign writePin  = write_pin_reg & ~reset;
  assign readPin   = read_pin_reg & ~reset;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int MEM_WORDS = 4;
`ifdef MEM_ACCESS_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0, reqReady, reqWrite = 1'b0, reqSigned = 1'b0;
  logic [1:0]  reqSize = 2'b10;
  logic [31:0] reqAddr = '0, reqWdata = '0;
  logic        respValid, respReady = 1'b0, respErr;
  logic [31:0] respRdata, adr, writeIn, readOut;
  logic        writePin, readPin;

  // Bench memory (the environment) and an independent reference copy.
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        load_en = 1'b0;
  int          load_idx = 0;
  logic [31:0] load_data = '0;

  int rd_total = 0, wr_total = 0;
  logic [31:0] rd_adr = '0, wr_adr = '0, wr_data = '0;
  bit both_seen = 1'b0;

  int n_cmp = 0, n_bad = 0;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqSize(reqSize), .reqSigned(reqSigned),
    .reqAddr(reqAddr), .reqWdata(reqWdata), .respValid(respValid),
    .respReady(respReady), .respRdata(respRdata), .respErr(respErr),
    .adr(adr), .writeIn(writeIn), .writePin(writePin), .readPin(readPin),
    .readOut(readOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
    else if (writePin && adr < MEM_WORDS) mem[adr[1:0]] <= writeIn;
    if (readPin && adr < MEM_WORDS) readOut <= mem[adr[1:0]];
  end

  always @(posedge clk) begin
    if (readPin) begin rd_total++; rd_adr = adr; end
    if (writePin) begin wr_total++; wr_adr = adr; wr_data = writeIn; end
    if (readPin && writePin) both_seen = 1'b1;
  end

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk); load_en = 1'b1; load_idx = idx; load_data = d;
    @(negedge clk); load_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Reference: the request's effect computed directly from address arithmetic.
  task automatic ref_access(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic err, output logic [31:0] rdata,
                            output logic [31:0] wword, output int lat,
                            output int nrd, output int nwr);
    logic [31:0] word, mask, v;
    int wi, sh;
    wi = int'(a >> 2);
    err = (sz == 2'b11) || (!SUBWORD && sz < 2) || (sz == 2'b01 && a[0]) ||
          (sz == 2'b10 && a[1:0] != 0) || ((a >> 2) >= MEM_WORDS);
    rdata = '0; wword = '0;
    if (err) begin lat = 1; nrd = 0; nwr = 0; return; end
    word = ref_mem[wi];
    sh   = int'(a[1:0]) * 8;
    mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (!w) begin
      v = (word >> sh) & mask;
      if (sg && sz != 2 && v > (mask >> 1)) v = v | ~mask;
      rdata = v; lat = 3; nrd = 1; nwr = 0;
    end else begin
      wword = (word & ~(mask << sh)) | ((wd & mask) << sh);
      ref_mem[wi] = wword;
      lat = (sz == 2) ? 2 : 4; nrd = (sz == 2) ? 0 : 1; nwr = 1;
    end
  endtask

  // Drives one request through to its handshake; returns observations only.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int nrd, output int nwr, output bit stable);
    int g, rc0, wc0;
    g = 0;
    @(negedge clk);
    while (!reqReady && g < 20) begin @(negedge clk); g++; end
    reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqWdata = wd;
    reqValid = 1'b1;
    rc0 = rd_total; wc0 = wr_total;
    @(posedge clk); @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 20) begin @(negedge clk); lat++; end
    rd = respRdata; er = respErr; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (respValid !== 1'b1 || respRdata !== rd || respErr !== er || reqReady !== 1'b0)
        stable = 1'b0;
    end
    respReady = 1'b1;
    @(posedge clk); @(negedge clk);
    respReady = 1'b0;
    nrd = rd_total - rc0; nwr = wr_total - wc0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    n_cmp++; if (reqReady !== 1'b1) begin n_bad++; $display("FAIL reset_reqReady got %b want 1", reqReady); end
    n_cmp++; if ({respValid, respErr, readPin, writePin} !== 4'b0)
      begin n_bad++; $display("FAIL reset_flags got %b want 0000", {respValid, respErr, readPin, writePin}); end
    n_cmp++; if (respRdata !== 32'h0 || adr !== 32'h0 || writeIn !== 32'h0)
      begin n_bad++; $display("FAIL reset_data rdata=%h adr=%h writeIn=%h want 0", respRdata, adr, writeIn); end
  endtask

  task automatic test_word_load();
    int lat, nrd, nwr, elat, erd, ewr; logic [31:0] rd, erdata, ew; logic er, eer; bit st;
    preload(2, 32'h8081_8283);
    ref_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, eer, erdata, ew, elat, erd, ewr);
    run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, lat, rd, er, nrd, nwr, st);
    n_cmp++; if (rd !== 32'h8081_8283 || er !== 1'b0)
      begin n_bad++; $display("FAIL word_load data=%h err=%b want 80818283/0", rd, er); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL word_load_latency got %0d want 3", lat); end
    n_cmp++; if (nrd !== 1 || nwr !== 0 || rd_adr !== 32'd2)
      begin n_bad++; $display("FAIL word_load_strobes rd=%0d wr=%0d adr=%0d want 1/0/2", nrd, nwr, rd_adr); end
  endtask

  task automatic test_byte_load();
    int lat, nrd, nwr, elat, erd, ewr; logic [31:0] rd, erdata, ew; logic er, eer; bit st;
    for (int s = 1; s >= 0; s--) begin
      ref_access(1'b0, 2'b00, s[0], 32'hB, 32'h0, eer, erdata, ew, elat, erd, ewr);
      run_req(1'b0, 2'b00, s[0], 32'hB, 32'h0, 0, lat, rd, er, nrd, nwr, st);
      n_cmp++; if (rd !== erdata || er !== eer || lat !== elat || nrd !== erd)
        begin n_bad++; $display("FAIL byte_load_s%0d got %h/%b/lat%0d/rd%0d want %h/%b/lat%0d/rd%0d",
                                s, rd, er, lat, nrd, erdata, eer, elat, erd); end
    end
  endtask

  task automatic test_half_store();
    int lat, nrd, nwr, elat, erd, ewr; logic [31:0] rd, erdata, ew; logic er, eer; bit st;
    preload(1, 32'h1122_3344);
    ref_access(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF, eer, erdata, ew, elat, erd, ewr);
    run_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF, 0, lat, rd, er, nrd, nwr, st);
    n_cmp++; if (er !== eer || lat !== elat || nrd !== erd || nwr !== ewr)
      begin n_bad++; $display("FAIL half_store err=%b lat=%0d rd=%0d wr=%0d want %b/%0d/%0d/%0d",
                              er, lat, nrd, nwr, eer, elat, erd, ewr); end
    n_cmp++; if (mem[1] !== ref_mem[1])
      begin n_bad++; $display("FAIL half_store_mem got %h want %h", mem[1], ref_mem[1]); end
    if (ewr == 1) begin
      n_cmp++; if (wr_data !== 32'hBEEF_3344 || wr_adr !== 32'd1)
        begin n_bad++; $display("FAIL half_store_wdata got %h@%0d want beef3344@1", wr_data, wr_adr); end
    end
  endtask

  task automatic test_errors();
    int lat, nrd, nwr; logic [31:0] rd; logic er; bit st;
    logic [31:0] addrs [2];
    addrs[0] = 32'h2; addrs[1] = 32'h10;
    for (int i = 0; i < 2; i++) begin
      run_req(1'b0, 2'b10, 1'b0, addrs[i], 32'h0, 0, lat, rd, er, nrd, nwr, st);
      n_cmp++; if (er !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0 || rd !== 32'h0)
        begin n_bad++; $display("FAIL error_%h err=%b lat=%0d rd=%0d wr=%0d data=%h want 1/1/0/0/0",
                                addrs[i], er, lat, nrd, nwr, rd); end
    end
  endtask

  task automatic test_backpressure();
    int lat, nrd, nwr; logic [31:0] rd; logic er; bit st;
    run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 5, lat, rd, er, nrd, nwr, st);
    n_cmp++; if (st !== 1'b1 || rd !== ref_mem[2])
      begin n_bad++; $display("FAIL backpressure_hold stable=%b data=%h want 1/%h", st, rd, ref_mem[2]); end
    n_cmp++; if (reqReady !== 1'b1 || respValid !== 1'b0)
      begin n_bad++; $display("FAIL backpressure_release reqReady=%b respValid=%b want 1/0", reqReady, respValid); end
  endtask

  task automatic test_reset_mid_wr();
    preload(3, 32'hCAFE_F00D);
    @(negedge clk);
    reqWrite = 1'b1; reqSize = 2'b10; reqAddr = 32'hC; reqWdata = 32'h1234_5678; reqValid = 1'b1;
    @(posedge clk); @(negedge clk);
    reqValid = 1'b0;
    n_cmp++; if (writePin !== 1'b1) begin n_bad++; $display("FAIL midwr_in_wr writePin=%b want 1", writePin); end
    reset = 1'b1; #1;
    n_cmp++; if (writePin !== 1'b0) begin n_bad++; $display("FAIL midwr_gate writePin=%b want 0", writePin); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({respValid, respErr, readPin, writePin} !== 4'b0 || respRdata !== 0 || adr !== 0 || writeIn !== 0)
      begin n_bad++; $display("FAIL midwr_outputs v=%b e=%b r=%b w=%b data=%h adr=%h wi=%h want 0",
                              respValid, respErr, readPin, writePin, respRdata, adr, writeIn); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem[3] !== 32'hCAFE_F00D || reqReady !== 1'b1)
      begin n_bad++; $display("FAIL midwr_mem got %h ready=%b want cafef00d/1", mem[3], reqReady); end
  endtask

  task automatic test_random();
    int lat, nrd, nwr, elat, erd, ewr, hold; logic [31:0] rd, erdata, ew, a, wd;
    logic er, eer, w, sg; logic [1:0] sz; bit st;
    for (int t = 0; t < 80; t++) begin
      w  = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = $urandom_range(0, 4 * MEM_WORDS + 3);
      if (sz == 2'b10 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd = $urandom; hold = $urandom_range(0, 3);
      ref_access(w, sz, sg, a, wd, eer, erdata, ew, elat, erd, ewr);
      run_req(w, sz, sg, a, wd, hold, lat, rd, er, nrd, nwr, st);
      n_cmp++;
      if (rd !== erdata || er !== eer || lat !== elat || nrd !== erd || nwr !== ewr || st !== 1'b1 ||
          (ewr == 1 && wr_data !== ew))
        begin n_bad++; $display("FAIL random_%0d w=%b sz=%0d a=%h got %h/%b/lat%0d/r%0d/w%0d/wd%h want %h/%b/lat%0d/r%0d/w%0d/wd%h",
                                t, w, sz, a, rd, er, lat, nrd, nwr, wr_data, erdata, eer, elat, erd, ewr, ew); end
    end
    for (int i = 0; i < MEM_WORDS; i++) begin
      n_cmp++; if (mem[i] !== ref_mem[i])
        begin n_bad++; $display("FAIL random_mem%0d got %h want %h", i, mem[i], ref_mem[i]); end
    end
    n_cmp++; if (both_seen !== 1'b0) begin n_bad++; $display("FAIL strobe_overlap got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom);
    test_word_load();
    test_byte_load();
    test_half_store();
    test_errors();
    test_backpressure();
    test_reset_mid_wr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
